dmi_jtag_access_ctrl: RTL and testbench
=======================================

// Module: dmi_jtag_access_ctrl
// PURPOSE
//  Sequences DMI transactions behind the JTAG TAP's DMIACCESS data register. Owns the 41-bit
//  {addr,data,op} DR, issues read/write requests to the debug module on Update-DR and collects
//  responses. Keeps the sticky DMI status that the TAP reports in dtmcs.dmistat.
//  Sits between the TAP (dmi_access/capture/shift/update strobes, dmi_tdi/dmi_tdo) and the DM request/response port.
// PARAMETERS
//  AbitsWidth  7   DMI address width; must match dtmcs.abits. DR width = AbitsWidth+34.
// PORTS
//  clk_i              in   1   TCK-domain clock; all state updates on rising edge
//  rst_i              in   1   asynchronous, active-high reset
//  dmi_access_i       in   1   IR currently selects DMIACCESS
//  capture_dr_i       in   1   TAP in Capture-DR
//  shift_dr_i         in   1   TAP in Shift-DR
//  update_dr_i        in   1   TAP in Update-DR
//  tlr_i              in   1   TAP in Test-Logic-Reset
//  dmi_reset_i        in   1   dtmcs.dmireset pulse; clears sticky status
//  dmi_tdi_i          in   1   serial data from TDI
//  dmi_tdo_o          out  1   DR bit 0 toward TAP TDO mux
//  dmi_error_o        out  2   sticky status: 0 ok, 2 op failed, 3 busy
//  req_valid_o        out  1   DMI request valid
//  req_ready_i        in   1   DM accepts request
//  req_op_o           out  2   1 read, 2 write
//  req_addr_o         out  AbitsWidth   request address
//  req_data_o         out  32  write data
//  resp_valid_i       in   1   DM response valid
//  resp_ready_o       out  1   controller accepts response
//  resp_data_i        in   32  read data
//  resp_resp_i        in   2   0 success, nonzero = failure
// BEHAVIOUR
//  Reset: state Idle, DR=0, addr_q/data_q=0, error_q=0; outputs dmi_tdo_o=0, dmi_error_o=0,
//   req_valid_o=0, resp_ready_o=0, req_op/addr/data=0.
//  DR layout: [AbitsWidth+33:34] addr, [33:2] data, [1:0] op. Shift LSB-first:
//   on shift_dr_i & dmi_access_i, dr <= {dmi_tdi_i, dr[MSB:1]}; dmi_tdo_o = dr[0] (combinational).
//  Capture (capture_dr_i & dmi_access_i): dr <= {addr_q, data_q, status}. status = 3 if FSM!=Idle
//   (and error_q set to 3 if it was 0), else error_q.
//  Update (update_dr_i & dmi_access_i): if error_q!=0 -> ignored.
//   Elif FSM!=Idle -> error_q<=3, op discarded. Elif op==1/2 -> latch addr_q, data_q (write);
//   FSM -> Read/Write. op==0 or 3 -> no request.
//  FSM: Idle -> (update rd/wr) -> Req: req_valid_o=1 from cycle after update; held with stable
//   op/addr/data until req_ready_i. -> Wait: resp_ready_o=1 until resp_valid_i.
//   On response: data_q<=resp_data_i (reads only); if resp_resp_i!=0 and error_q==0 -> error_q<=2. -> Idle.
//   Minimum update-to-Idle: 2 cycles (ready and valid both already high).
//  dmi_reset_i: error_q<=0; takes priority over a same-cycle busy/failed set. Does not abort FSM.
//  tlr_i: dr<=0, error_q<=0. An in-flight transaction still completes (handshakes honoured,
//   response consumed), but on a read data_q is not written.
//  Capture/shift/update without dmi_access_i: no state change.
//  rst_i mid-transaction: immediate return to reset values; the DM side is reset by the same source.
// STRUCTURE
//  Shared package dm_jtag_pkg: dtm_op_e {DtmNop=0,DtmRead=1,DtmWrite=2}, dmi_status_e {Ok=0,Failed=2,
//   Busy=3}, dmi_req_t {addr,op,data}, dmi_resp_t {data,resp}; port bundles use these structs.
//  One sub-module natural: dmi_jtag_dr_shift (parameterised capture/shift register); FSM and status
//   in the top.
// TESTING
//  Write: shift {addr=7'h10,data=32'hDEADBEEF,op=2}, update, ready=1 -> one req cycle op=2 addr=10, error stays 0.
//  Read: update op=1 addr=7'h11; resp data=32'h12345678 after 5 cycles; capture -> dr shifts out op=0, data=12345678.
//  Busy: update op=1 with ready held 0; capture -> op field=3, dmi_error_o=3; next update ignored (no second req).
//  Failure/clear: resp_resp_i=2 -> dmi_error_o=2; dmi_reset_i pulse -> 0; dmi_reset_i with busy capture same cycle -> 0.
//  TLR in flight: read pending, tlr_i pulse -> error 0, dr=0; response accepted, data_q unchanged, FSM Idle.
//  Async rst_i asserted during Req -> req_valid_o low same cycle, all outputs reset values.

Source files
------------

// File: rtl/dm_jtag_pkg.sv
// Shared types for the JTAG DTM <-> debug module interface.
package dm_jtag_pkg;

  localparam int unsigned DmiDataWidth = 32;

  typedef enum logic [1:0] {
    DtmNop   = 2'd0,
    DtmRead  = 2'd1,
    DtmWrite = 2'd2
  } dtm_op_e;

  typedef enum logic [1:0] {
    Ok     = 2'd0,
    Failed = 2'd2,
    Busy   = 2'd3
  } dmi_status_e;

  typedef struct packed {
    logic [6:0]              addr;
    dtm_op_e                 op;
    logic [DmiDataWidth-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [DmiDataWidth-1:0] data;
    logic [1:0]              resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } dmi_fsm_e;

  function automatic logic is_req_op(input logic [1:0] op);
    return (op == DtmRead) || (op == DtmWrite);
  endfunction

endpackage

// File: rtl/dmi_jtag_dr_shift.sv
// Capture/shift data register, LSB-first toward TDO.
module dmi_jtag_dr_shift #(
  parameter int unsigned Width = 41
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_capture,
  input  logic [Width-1:0] i_capture_data,
  input  logic             i_shift,
  input  logic             i_tdi,
  output logic [Width-1:0] o_dr,
  output logic             o_tdo
);

  logic [Width-1:0] r_dr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dr <= '0;
    end else if (i_clr) begin
      r_dr <= '0;
    end else if (i_capture) begin
      r_dr <= i_capture_data;
    end else if (i_shift) begin
      r_dr <= {i_tdi, r_dr[Width-1:1]};
    end
  end

  assign o_dr  = r_dr;
  assign o_tdo = r_dr[0];

endmodule

// File: rtl/dmi_jtag_access_ctrl.sv
// DMIACCESS register owner: turns Update-DR into DMI requests and tracks sticky dmistat.
module dmi_jtag_access_ctrl
  import dm_jtag_pkg::*;
#(
  parameter int unsigned AbitsWidth = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmi_access_i,
  input  logic                  capture_dr_i,
  input  logic                  shift_dr_i,
  input  logic                  update_dr_i,
  input  logic                  tlr_i,
  input  logic                  dmi_reset_i,
  input  logic                  dmi_tdi_i,
  output logic                  dmi_tdo_o,
  output logic [1:0]            dmi_error_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [1:0]            req_op_o,
  output logic [AbitsWidth-1:0] req_addr_o,
  output logic [31:0]           req_data_o,
  input  logic                  resp_valid_i,
  output logic                  resp_ready_o,
  input  logic [31:0]           resp_data_i,
  input  logic [1:0]            resp_resp_i
);

  localparam int unsigned DrWidth = AbitsWidth + 34;

  dmi_fsm_e               r_state;
  dmi_fsm_e               w_state_d;
  dtm_op_e                r_op_q;
  logic [AbitsWidth-1:0]  r_addr_q;
  logic [31:0]            r_data_q;
  logic [1:0]             r_error_q;
  logic [1:0]             w_error_d;
  logic                   r_drop_q;

  logic                   w_capture;
  logic                   w_shift;
  logic                   w_update;
  logic                   w_busy;
  logic                   w_launch;
  logic                   w_resp_fire;
  logic [1:0]             w_status;
  logic [DrWidth-1:0]     w_dr;
  logic [DrWidth-1:0]     w_capture_data;
  logic [AbitsWidth-1:0]  w_dr_addr;
  logic [31:0]            w_dr_data;
  logic [1:0]             w_dr_op;
  dmi_resp_t              w_resp;

  assign w_capture = capture_dr_i & dmi_access_i;
  assign w_shift   = shift_dr_i & dmi_access_i;
  assign w_update  = update_dr_i & dmi_access_i;
  assign w_busy    = (r_state != StIdle);
  assign w_resp    = {resp_data_i, resp_resp_i};

  assign w_dr_addr = w_dr[DrWidth-1:34];
  assign w_dr_data = w_dr[33:2];
  assign w_dr_op   = w_dr[1:0];

  assign w_status       = w_busy ? Busy : r_error_q;
  assign w_capture_data = {r_addr_q, r_data_q, w_status};

  assign w_launch    = (r_state == StIdle) && w_update && (r_error_q == Ok) && is_req_op(w_dr_op);
  assign w_resp_fire = (r_state == StWait) && resp_valid_i;

  dmi_jtag_dr_shift #(
    .Width (DrWidth)
  ) u_dr (
    .i_clk          (clk_i),
    .i_rst          (rst_i),
    .i_clr          (tlr_i),
    .i_capture      (w_capture),
    .i_capture_data (w_capture_data),
    .i_shift        (w_shift),
    .i_tdi          (dmi_tdi_i),
    .o_dr           (w_dr),
    .o_tdo          (dmi_tdo_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    req_valid_o  = 1'b0;
    resp_ready_o = 1'b0;
    req_op_o     = DtmNop;
    unique case (r_state)
      StIdle: begin
        if (w_launch) w_state_d = StReq;
      end
      StReq: begin
        req_valid_o = 1'b1;
        req_op_o    = r_op_q;
        if (req_ready_i) w_state_d = StWait;
      end
      StWait: begin
        resp_ready_o = 1'b1;
        if (resp_valid_i) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Later assignments win: busy overrides failed, and clears override everything.
  always_comb begin
    w_error_d = r_error_q;
    if (w_resp_fire && (w_resp.resp != 2'd0) && (r_error_q == Ok)) w_error_d = Failed;
    if (w_capture && w_busy && (r_error_q == Ok)) w_error_d = Busy;
    if (w_update && w_busy && (r_error_q == Ok)) w_error_d = Busy;
    if (dmi_reset_i || tlr_i) w_error_d = Ok;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_error_q <= Ok;
    end else begin
      r_error_q <= w_error_d;
    end
  end

  // A TLR while a transaction is in flight must keep its read data out of data_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op_q   <= DtmNop;
      r_addr_q <= '0;
      r_data_q <= '0;
      r_drop_q <= 1'b0;
    end else begin
      if (w_launch) begin
        r_op_q   <= dtm_op_e'(w_dr_op);
        r_addr_q <= w_dr_addr;
        if (w_dr_op == DtmWrite) r_data_q <= w_dr_data;
      end
      if (w_resp_fire && (r_op_q == DtmRead) && !r_drop_q && !tlr_i) begin
        r_data_q <= w_resp.data;
      end
      if (w_resp_fire) begin
        r_drop_q <= 1'b0;
      end else if (tlr_i && w_busy) begin
        r_drop_q <= 1'b1;
      end
    end
  end

  assign dmi_error_o = r_error_q;
  assign req_addr_o  = r_addr_q;
  assign req_data_o  = r_data_q;

endmodule

// File: tb/tb_dmi_jtag_access_ctrl.sv
// Directed bench for dmi_jtag_access_ctrl: vector table plus multi-cycle corner sequences.
module tb_dmi_jtag_access_ctrl;

  logic        clk;
  logic        rst;
  logic        dmi_access;
  logic        capture_dr;
  logic        shift_dr;
  logic        update_dr;
  logic        tlr;
  logic        dmi_reset;
  logic        tdi;
  logic        tdo;
  logic [1:0]  dmi_error;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_resp;

  int n_vec;
  int n_err;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int unsigned delay;
    logic [1:0]  exp_err;
    logic [40:0] exp_dr;
  } vec_t;

  vec_t vecs[4];

  dmi_jtag_access_ctrl #(
    .AbitsWidth (7)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .dmi_access_i (dmi_access),
    .capture_dr_i (capture_dr),
    .shift_dr_i   (shift_dr),
    .update_dr_i  (update_dr),
    .tlr_i        (tlr),
    .dmi_reset_i  (dmi_reset),
    .dmi_tdi_i    (tdi),
    .dmi_tdo_o    (tdo),
    .dmi_error_o  (dmi_error),
    .req_valid_o  (req_valid),
    .req_ready_i  (req_ready),
    .req_op_o     (req_op),
    .req_addr_o   (req_addr),
    .req_data_o   (req_data),
    .resp_valid_i (resp_valid),
    .resp_ready_o (resp_ready),
    .resp_data_i  (resp_data),
    .resp_resp_i  (resp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture, shift 41 bits LSB-first, then Update (optionally with DMIACCESS deselected).
  task automatic scan(input logic [40:0] din, output logic [40:0] dout, input logic upd_acc);
    dmi_access = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr   = 1'b1;
    for (int i = 0; i < 41; i++) begin
      tdi     = din[i];
      dout[i] = tdo;
      tick();
    end
    shift_dr   = 1'b0;
    tdi        = 1'b0;
    dmi_access = upd_acc;
    update_dr  = 1'b1;
    tick();
    update_dr  = 1'b0;
    dmi_access = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [1:0] rsp);
    resp_valid = 1'b1;
    resp_data  = data;
    resp_resp  = rsp;
    tick();
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_resp  = '0;
  endtask

  task automatic accept_req();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic pulse_dmi_reset();
    dmi_reset = 1'b1;
    tick();
    dmi_reset = 1'b0;
  endtask

  initial begin
    logic [40:0] dout;
    n_vec = 0;
    n_err = 0;

    vecs[0] = '{op: 2'd2, addr: 7'h10, wdata: 32'hDEADBEEF, rdata: 32'h0, resp: 2'd0, delay: 0,
                exp_err: 2'd0, exp_dr: {7'h10, 32'hDEADBEEF, 2'd0}};
    vecs[1] = '{op: 2'd1, addr: 7'h11, wdata: 32'hFFFF0000, rdata: 32'h12345678, resp: 2'd0, delay: 5,
                exp_err: 2'd0, exp_dr: {7'h11, 32'h12345678, 2'd0}};
    vecs[2] = '{op: 2'd2, addr: 7'h7F, wdata: 32'hA5A50F0F, rdata: 32'h0, resp: 2'd0, delay: 2,
                exp_err: 2'd0, exp_dr: {7'h7F, 32'hA5A50F0F, 2'd0}};
    vecs[3] = '{op: 2'd1, addr: 7'h00, wdata: 32'h11111111, rdata: 32'hFFFFFFFF, resp: 2'd2, delay: 1,
                exp_err: 2'd2, exp_dr: {7'h00, 32'hFFFFFFFF, 2'd2}};

    rst = 1'b1; dmi_access = 0; capture_dr = 0; shift_dr = 0; update_dr = 0;
    tlr = 0; dmi_reset = 0; tdi = 0; req_ready = 0; resp_valid = 0; resp_data = '0; resp_resp = '0;
    tick();
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_err", 64'(dmi_error), 64'd0);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_resp_ready", 64'(resp_ready), 64'd0);
    check("rst_req_fields", {req_op, req_addr, req_data}, 64'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      scan({vecs[v].addr, vecs[v].wdata, vecs[v].op}, dout, 1'b1);
      check($sformatf("v%0d_req_valid", v), 64'(req_valid), 64'd1);
      check($sformatf("v%0d_req_op", v), 64'(req_op), 64'(vecs[v].op));
      check($sformatf("v%0d_req_addr", v), 64'(req_addr), 64'(vecs[v].addr));
      if (vecs[v].op == 2'd2) check($sformatf("v%0d_req_data", v), 64'(req_data), 64'(vecs[v].wdata));
      accept_req();
      check($sformatf("v%0d_req_dropped", v), 64'(req_valid), 64'd0);
      for (int unsigned d = 0; d < vecs[v].delay; d++) tick();
      check($sformatf("v%0d_resp_ready", v), 64'(resp_ready), 64'd1);
      respond(vecs[v].rdata, vecs[v].resp);
      check($sformatf("v%0d_idle", v), 64'(resp_ready), 64'd0);
      check($sformatf("v%0d_err", v), 64'(dmi_error), 64'(vecs[v].exp_err));
      scan(41'd0, dout, 1'b1);
      check($sformatf("v%0d_capture", v), 64'(dout), 64'(vecs[v].exp_dr));
      check($sformatf("v%0d_no_req_nop", v), 64'(req_valid), 64'd0);
    end

    pulse_dmi_reset();
    check("fail_cleared", 64'(dmi_error), 64'd0);

    // Update with DMIACCESS deselected must not launch; a later selected update does.
    scan({7'h05, 32'h0BADF00D, 2'd2}, dout, 1'b0);
    check("noacc_no_req", 64'(req_valid), 64'd0);
    dmi_access = 1'b1; update_dr = 1'b1;
    tick();
    dmi_access = 1'b0; update_dr = 1'b0;
    check("acc_req_valid", 64'(req_valid), 64'd1);
    check("acc_req_fields", {req_op, req_addr, req_data}, {25'd0, 2'd2, 7'h05, 32'h0BADF00D});
    accept_req();
    respond(32'h0, 2'd0);

    // Busy: request stalled, capture reports busy, overlapping update is dropped.
    scan({7'h22, 32'h0, 2'd1}, dout, 1'b1);
    check("busy_req_valid", 64'(req_valid), 64'd1);
    scan({7'h23, 32'h0, 2'd2}, dout, 1'b1);
    check("busy_capture", 64'(dout), 64'({7'h22, 32'h0BADF00D, 2'd3}));
    check("busy_err", 64'(dmi_error), 64'd3);
    check("busy_held", {req_valid, req_op, req_addr}, {54'd0, 1'b1, 2'd1, 7'h22});
    accept_req();
    respond(32'h5555AAAA, 2'd0);
    check("busy_done_idle", {req_valid, resp_ready}, 64'd0);
    check("busy_err_sticky", 64'(dmi_error), 64'd3);
    pulse_dmi_reset();
    check("busy_cleared", 64'(dmi_error), 64'd0);

    // dmireset wins over a busy capture in the same cycle.
    scan({7'h24, 32'h0, 2'd1}, dout, 1'b1);
    dmi_access = 1'b1; capture_dr = 1'b1; dmi_reset = 1'b1;
    tick();
    dmi_access = 1'b0; capture_dr = 1'b0; dmi_reset = 1'b0;
    check("rst_vs_busy_err", 64'(dmi_error), 64'd0);
    check("rst_vs_busy_tdo", 64'(tdo), 64'd1);
    accept_req();
    respond(32'h01020304, 2'd0);
    check("rst_vs_busy_err_end", 64'(dmi_error), 64'd0);

    // TLR with a read in flight: status and DR cleared, response consumed, data_q untouched.
    scan({7'h33, 32'h0, 2'd1}, dout, 1'b1);
    dmi_access = 1'b1; capture_dr = 1'b1;
    tick();
    dmi_access = 1'b0; capture_dr = 1'b0;
    check("tlr_pre_err", 64'(dmi_error), 64'd3);
    accept_req();
    tlr = 1'b1;
    tick();
    tlr = 1'b0;
    check("tlr_err", 64'(dmi_error), 64'd0);
    dmi_access = 1'b1; shift_dr = 1'b1; tdi = 1'b0;
    for (int i = 0; i < 41; i++) begin
      dout[i] = tdo;
      tick();
    end
    dmi_access = 1'b0; shift_dr = 1'b0;
    check("tlr_dr_zero", 64'(dout), 64'd0);
    check("tlr_still_wait", 64'(resp_ready), 64'd1);
    respond(32'hCAFEF00D, 2'd0);
    check("tlr_idle", 64'(resp_ready), 64'd0);
    scan(41'd0, dout, 1'b1);
    check("tlr_data_kept", 64'(dout), 64'({7'h33, 32'h01020304, 2'd0}));

    // Asynchronous reset in the middle of a request.
    scan({7'h44, 32'h76543210, 2'd2}, dout, 1'b1);
    check("arst_pre_valid", 64'(req_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req_valid", 64'(req_valid), 64'd0);
    check("arst_fields", {req_op, req_addr, req_data}, 64'd0);
    check("arst_misc", {dmi_error, resp_ready, tdo}, 64'd0);
    #2 rst = 1'b0;
    tick();
    check("arst_stays_idle", {req_valid, resp_ready}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
